// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// scan FSM state encoding and the hex-to-segment table (bits 6:0 = g..a).
package seg_pkg;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_GUARD = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg_scan_hex_seg.sv
// Combinational hex nibble to active-high segment encoder; the inverse of
// the segment-to-hex decoder so the two can be looped back.
module hex_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = seg_encode(hex_i);
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed seven-segment scanner with blank guard time between digits,
// a one-entry input buffer, and display updates only at frame boundaries.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GUARD  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  blank_lz,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CNT_MAX = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  scan_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [4*DIGITS-1:0]  disp_q, disp_d;
  logic [DIGITS-1:0]    disp_dp_q, disp_dp_d;
  logic [4*DIGITS-1:0]  pend_q, pend_d;
  logic [DIGITS-1:0]    pend_dp_q, pend_dp_d;
  logic                 pend_full_q, pend_full_d;

  logic                 boundary;
  logic                 accept;
  logic [3:0]           cur_nib;
  logic                 cur_dp;
  logic                 cur_lz;
  logic [6:0]           cur_enc;
  logic [DIGITS-1:0]    lz;
  logic                 zrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_GUARD;
      cnt_q       <= '0;
      idx_q       <= IW'(DIGITS-1);
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      pend_q      <= pend_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
    end
  end

  // The frame boundary is the GUARD->SHOW step that wraps idx back to digit 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    boundary = 1'b0;
    case (state_q)
      ST_SHOW: begin
        if (cnt_q == CW'(DIV-1)) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == CW'(GUARD-1)) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          if (idx_q == IW'(DIGITS-1)) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    accept      = din_valid && !pend_full_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    if (boundary && pend_full_q) begin
      disp_d      = pend_q;
      disp_dp_d   = pend_dp_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = din;
      pend_dp_d   = dp_in;
      pend_full_d = 1'b1;
    end
  end

  // lz[i] is set when every displayed nibble at position i and above is zero.
  always_comb begin
    lz   = '0;
    zrun = 1'b1;
    for (int i = DIGITS-1; i >= 0; i--) begin
      zrun  = zrun && (disp_q[4*i +: 4] == 4'h0);
      lz[i] = zrun;
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    an      = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib = disp_q[4*i +: 4];
        cur_dp  = disp_dp_q[i];
        cur_lz  = lz[i] && (i != 0);
        an[i]   = (state_q != ST_SHOW);
      end
    end
  end

  hex_seg u_hex_seg (
    .hex_i (cur_nib),
    .seg_o (cur_enc)
  );

  always_comb begin
    seg = 8'h00;
    if (state_q == ST_SHOW) begin
      seg = {cur_dp, (blank_lz && cur_lz) ? 7'h00 : cur_enc};
    end
  end

  assign din_ready  = !pend_full_q;
  assign frame_done = boundary && !rst;

endmodule

// File: tb/tb_seg_scan.sv
// Directed self-checking bench for seg_scan with DIGITS=4, DIV=4, GUARD=2,
// so each digit slot is 6 cycles and a frame is 24 cycles.
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic [3:0]  dp_in = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        blank_lz = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int an_bad = 0;

  seg_scan #(.DIGITS(4), .DIV(4), .GUARD(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dp_in      (dp_in),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // an must be all ones or have exactly one low bit in every cycle
  always @(negedge clk) begin
    if (!rst && !(an == 4'hF || $onehot(~an))) an_bad++;
  end

  function automatic logic [4:0] seg_to_hex(input logic [6:0] s);
    case (s)
      7'h3f: return 5'h00; 7'h06: return 5'h01; 7'h5b: return 5'h02; 7'h4f: return 5'h03;
      7'h66: return 5'h04; 7'h6d: return 5'h05; 7'h7d: return 5'h06; 7'h07: return 5'h07;
      7'h7f: return 5'h08; 7'h6f: return 5'h09; 7'h77: return 5'h0a; 7'h7c: return 5'h0b;
      7'h39: return 5'h0c; 7'h5e: return 5'h0d; 7'h79: return 5'h0e; 7'h71: return 5'h0f;
      default: return 5'h10;
    endcase
  endfunction

  task automatic wait_frame_done(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) ok = 1;
    end
    if (!ok) begin
      checks++;
      $display("FAIL frame_done_timeout: got no pulse, required one within %0d cycles", budget);
    end
  endtask

  // Called on the boundary negedge; samples each digit in its first SHOW cycle.
  task automatic capture_frame(output logic [31:0] segs, output logic [15:0] ans, output logic rdy1);
    for (int d = 0; d < 4; d++) begin
      repeat (d == 0 ? 1 : 6) @(negedge clk);
      segs[8*d +: 8] = seg;
      ans[4*d +: 4]  = an;
      if (d == 0) rdy1 = din_ready;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (an !== 4'hF) $display("FAIL reset_an: got %b required 1111", an); else passed++;
    checks++; if (seg !== 8'h00) $display("FAIL reset_seg: got %h required 00", seg); else passed++;
    checks++; if (din_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", din_ready); else passed++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b required 0", frame_done); else passed++;
  endtask

  task automatic test_scan_timing();
    logic [3:0] exp_an [9] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};
    logic       exp_fd;
    rst = 1'b0;
    #1;
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 9) begin
        checks++;
        if (an !== exp_an[k]) $display("FAIL scan_an[%0d]: got %b required %b", k, an, exp_an[k]);
        else passed++;
      end
      exp_fd = (k == 1 || k == 25);
      checks++;
      if (frame_done !== exp_fd) $display("FAIL scan_frame_done[%0d]: got %b required %b", k, frame_done, exp_fd);
      else passed++;
      if (k == 2) begin
        checks++;
        if (seg !== 8'h3F) $display("FAIL scan_seg_zero: got %h required 3f", seg); else passed++;
      end
    end
  endtask

  task automatic test_encode();
    logic [31:0] segs; logic [15:0] ans; logic rdy1;
    blank_lz = 1'b0;
    din = 16'h12AF; dp_in = 4'b0100; din_valid = 1'b1;
    checks++; if (din_ready !== 1'b1) $display("FAIL enc_ready_before: got %b required 1", din_ready); else passed++;
    @(negedge clk);
    din_valid = 1'b0;
    checks++; if (din_ready !== 1'b0) $display("FAIL enc_ready_after_accept: got %b required 0", din_ready); else passed++;
    wait_frame_done(60);
    checks++; if (din_ready !== 1'b0) $display("FAIL enc_ready_at_boundary: got %b required 0", din_ready); else passed++;
    capture_frame(segs, ans, rdy1);
    checks++; if (rdy1 !== 1'b1) $display("FAIL enc_ready_after_boundary: got %b required 1", rdy1); else passed++;
    checks++; if (segs !== 32'h06DB7771) $display("FAIL enc_segs: got %h required 06db7771", segs); else passed++;
    checks++; if (ans !== 16'h7BDE) $display("FAIL enc_an: got %h required 7bde", ans); else passed++;
  endtask

  task automatic test_blank_lz();
    logic [31:0] segs; logic [15:0] ans; logic rdy1;
    din = 16'h0050; dp_in = 4'b0000; din_valid = 1'b1; blank_lz = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    wait_frame_done(60);
    capture_frame(segs, ans, rdy1);
    checks++; if (segs !== 32'h00006D3F) $display("FAIL blank_on_segs: got %h required 00006d3f", segs); else passed++;
    blank_lz = 1'b0;
    wait_frame_done(60);
    capture_frame(segs, ans, rdy1);
    checks++; if (segs !== 32'h3F3F6D3F) $display("FAIL blank_off_segs: got %h required 3f3f6d3f", segs); else passed++;
  endtask

  task automatic test_back_to_back();
    bit found = 0;
    int early = 0;
    int t0;
    din = 16'h1111; dp_in = 4'b0000; din_valid = 1'b1;
    checks++; if (din_ready !== 1'b1) $display("FAIL b2b_ready_initial: got %b required 1", din_ready); else passed++;
    @(negedge clk);
    checks++; if (din_ready !== 1'b0) $display("FAIL b2b_first_accept: got %b required 0", din_ready); else passed++;
    din = 16'h2222;
    for (int i = 0; i < 60 && !found; i++) begin
      if (frame_done === 1'b1) found = 1;
      else begin
        if (din_ready !== 1'b0) early++;
        @(negedge clk);
      end
    end
    checks++; if (!found) $display("FAIL b2b_boundary_timeout: got none required pulse"); else passed++;
    checks++; if (early != 0) $display("FAIL b2b_ready_held_low: got %0d high cycles required 0", early); else passed++;
    t0 = cyc;
    @(negedge clk);
    checks++; if (din_ready !== 1'b1) $display("FAIL b2b_ready_rise: got %b required 1", din_ready); else passed++;
    checks++; if (seg !== 8'h06) $display("FAIL b2b_show_1111: got %h required 06", seg); else passed++;
    @(negedge clk);
    din_valid = 1'b0;
    checks++; if (din_ready !== 1'b0) $display("FAIL b2b_second_accept: got %b required 0", din_ready); else passed++;
    wait_frame_done(60);
    checks++; if (cyc - t0 != 24) $display("FAIL b2b_frame_len: got %0d required 24", cyc - t0); else passed++;
    @(negedge clk);
    checks++; if (seg !== 8'h5B) $display("FAIL b2b_show_2222: got %h required 5b", seg); else passed++;
  endtask

  task automatic test_boundary_accept();
    wait_frame_done(60);
    din = 16'h3333; dp_in = 4'b0000; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    checks++; if (frame_done !== 1'b0) $display("FAIL bnd_pulse1_width: got %b required 0", frame_done); else passed++;
    checks++; if (din_ready !== 1'b0) $display("FAIL bnd_accept: got %b required 0", din_ready); else passed++;
    checks++; if (seg !== 8'h5B) $display("FAIL bnd_not_yet_shown: got %h required 5b", seg); else passed++;
    wait_frame_done(60);
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) $display("FAIL bnd_pulse2_width: got %b required 0", frame_done); else passed++;
    checks++; if (seg !== 8'h4F) $display("FAIL bnd_shown_next: got %h required 4f", seg); else passed++;
  endtask

  task automatic test_loopback();
    logic [15:0] vals [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    logic [31:0] segs; logic [15:0] ans; logic rdy1;
    logic [4:0]  got;
    blank_lz = 1'b0;
    for (int v = 0; v < 4; v++) begin
      din = vals[v]; dp_in = 4'b0000; din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      wait_frame_done(60);
      capture_frame(segs, ans, rdy1);
      for (int d = 0; d < 4; d++) begin
        got = seg_to_hex(segs[8*d +: 7]);
        checks++;
        if (got !== {1'b0, vals[v][4*d +: 4]})
          $display("FAIL loopback_%h_d%0d: got %h required %h", vals[v], d, got, vals[v][4*d +: 4]);
        else passed++;
      end
    end
    checks++; if (an_bad != 0) $display("FAIL an_onehot: got %0d bad cycles required 0", an_bad); else passed++;
  endtask

  task automatic test_reset_midframe();
    din = 16'h9999; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    wait_frame_done(60);
    repeat (3) @(negedge clk);
    din = 16'h8888; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (an !== 4'hF) $display("FAIL mid_reset_an: got %b required 1111", an); else passed++;
    checks++; if (din_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b required 1", din_ready); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (frame_done !== 1'b1) $display("FAIL mid_first_boundary: got %b required 1", frame_done); else passed++;
    @(negedge clk);
    checks++; if (seg !== 8'h3F || an !== 4'hE) $display("FAIL mid_disp_cleared: got %h/%b required 3f/1110", seg, an); else passed++;
    wait_frame_done(60);
    @(negedge clk);
    checks++; if (seg !== 8'h3F) $display("FAIL mid_pend_discarded: got %h required 3f", seg); else passed++;
  endtask

  initial begin
    test_reset();
    test_scan_timing();
    test_encode();
    test_blank_lz();
    test_back_to_back();
    test_boundary_accept();
    test_loopback();
    test_reset_midframe();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
